// File: rtl/tt_sweep_ctrl.sv
// Exhaustive input-vector sweeper that scores a candidate circuit against a golden one.
// Optional TT_SWEEP_EARLY_EXIT_EN ends the sweep on the first mismatching vector.
module tt_sweep_ctrl #(
    parameter int N_IN  = 6,
    parameter int N_OUT = 12,
    parameter int ERR_W = N_IN + $clog2(N_OUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [N_OUT-1:0] out_mask,
    output logic [N_IN-1:0]  vec,
    input  logic [N_OUT-1:0] ref_po,
    input  logic [N_OUT-1:0] dut_po,
    output logic             busy,
    output logic             done,
    output logic [ERR_W-1:0] err_count,
    output logic             fail,
    output logic [N_IN-1:0]  first_fail_vec
);

    localparam int PC_W = $clog2(N_OUT + 1);
    localparam logic [N_IN-1:0] VEC_LAST = '1;
    localparam logic [N_IN-1:0] VEC_ONE  = 1;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t            state, state_d;
    logic [N_IN-1:0]   vec_d, ffv_d;
    logic [ERR_W-1:0]  err_d;
    logic              fail_d, done_d;
    logic [N_OUT-1:0]  mask_q, mask_d;
    logic [PC_W-1:0]   vec_err;

    function automatic logic [PC_W-1:0] popcount(input logic [N_OUT-1:0] bits);
        logic [PC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < N_OUT; i++) cnt = cnt + PC_W'(bits[i]);
        return cnt;
    endfunction

    assign vec_err = popcount((ref_po ^ dut_po) & mask_q);
    assign busy    = (state == SWEEP);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_d = state;
        vec_d   = vec;
        err_d   = err_count;
        fail_d  = fail;
        ffv_d   = first_fail_vec;
        mask_d  = mask_q;
        done_d  = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    err_d   = '0;
                    fail_d  = 1'b0;
                    ffv_d   = '0;
                    mask_d  = out_mask;
                    vec_d   = '0;
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                err_d = err_count + ERR_W'(vec_err);
                if (vec_err != '0 && !fail) begin
                    fail_d = 1'b1;
                    ffv_d  = vec;
                end
                // abort outranks both the terminal vector and an early exit
                if (abort) begin
                    state_d = IDLE;
`ifdef TT_SWEEP_EARLY_EXIT_EN
                end else if (vec_err != '0 && !fail) begin
                    state_d = DONE;
                    done_d  = 1'b1;
`endif
                end else if (vec == VEC_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    vec_d = vec + VEC_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // done is registered on the SWEEP->DONE edge, so it is high only in the first DONE cycle
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
        if (rst) begin
            state          <= IDLE;
            vec            <= '0;
            done           <= 1'b0;
            err_count      <= '0;
            fail           <= 1'b0;
            first_fail_vec <= '0;
            mask_q         <= '1;
        end else begin
            state          <= state_d;
            vec            <= vec_d;
            done           <= done_d;
            err_count      <= err_d;
            fail           <= fail_d;
            first_fail_vec <= ffv_d;
            mask_q         <= mask_d;
        end
    end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Directed bench for tt_sweep_ctrl: table of full sweeps plus start/abort/reset corner sequences.
module tb_tt_sweep_ctrl;

    localparam int N_IN  = 6;
    localparam int N_OUT = 12;
    localparam int ERR_W = 10;

    logic             clk = 1'b0;
    logic             rst, start, abort;
    logic [N_OUT-1:0] out_mask, ref_po, dut_po;
    logic [N_IN-1:0]  vec, first_fail_vec;
    logic             busy, done, fail;
    logic [ERR_W-1:0] err_count;

    int tests = 0;
    int failed = 0;
    int mode = 0;  // 0 equal, 1 bit0 flipped, 2 three bits flipped at vec 37, 3 all inverted

    always #5 clk = ~clk;

    tt_sweep_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .out_mask(out_mask),
        .vec(vec), .ref_po(ref_po), .dut_po(dut_po), .busy(busy), .done(done),
        .err_count(err_count), .fail(fail), .first_fail_vec(first_fail_vec)
    );

    always_comb begin
        ref_po = {vec, vec ^ 6'h2A};
        dut_po = ref_po;
        case (mode)
            1: dut_po = ref_po ^ 12'h001;
            2: if (vec == 6'd37) dut_po = ref_po ^ 12'h421;
            3: dut_po = ~ref_po;
            default: dut_po = ref_po;
        endcase
    end

    typedef struct {
        int         mode;
        logic [11:0] mask;
        int         err;
        int         fail;
        int         ffv;
        int         cycles;
    } sweep_t;

    sweep_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_sweep(input int m, input logic [11:0] mask);
        mode     = m;
        out_mask = mask;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        check("start_busy", 32'(busy), 1);
        check("start_vec", 32'(vec), 0);
    endtask

    // Counts busy cycles from the current one, then checks the done cycle's results.
    task automatic finish_sweep(input string name, input int cycles, input int err,
                                input int fl, input int ffv);
        int cnt = 0;
        while (busy && cnt < 200) begin
            cnt++;
            check({name, "_no_done_while_busy"}, 32'(done), 0);
            tick();
        end
        check({name, "_busy_cycles"}, cnt, cycles);
        check({name, "_done"}, 32'(done), 1);
        check({name, "_err"}, 32'(err_count), err);
        check({name, "_fail"}, 32'(fail), fl);
        check({name, "_ffv"}, 32'(first_fail_vec), ffv);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_mask = 12'hFFF;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_vec", 32'(vec), 0);
        check("rst_err", 32'(err_count), 0);
        check("rst_fail", 32'(fail), 0);
        check("rst_ffv", 32'(first_fail_vec), 0);
        tick();

`ifdef TT_SWEEP_EARLY_EXIT_EN
        tbl[0] = '{0, 12'hFFF, 0,  0, 0,  64};
        tbl[1] = '{1, 12'hFFF, 1,  1, 0,  1};
        tbl[2] = '{1, 12'hFFE, 0,  0, 0,  64};
        tbl[3] = '{2, 12'hFFF, 3,  1, 37, 38};
        tbl[4] = '{3, 12'hFFF, 12, 1, 0,  1};
        tbl[5] = '{2, 12'h020, 1,  1, 37, 38};
`else
        tbl[0] = '{0, 12'hFFF, 0,   0, 0,  64};
        tbl[1] = '{1, 12'hFFF, 64,  1, 0,  64};
        tbl[2] = '{1, 12'hFFE, 0,   0, 0,  64};
        tbl[3] = '{2, 12'hFFF, 3,   1, 37, 64};
        tbl[4] = '{3, 12'hFFF, 768, 1, 0,  64};
        tbl[5] = '{2, 12'h020, 1,   1, 37, 64};
`endif

        for (int i = 0; i < 6; i++) begin
            begin_sweep(tbl[i].mode, tbl[i].mask);
            out_mask = ~tbl[i].mask;  // mask must stay latched from the start edge
            finish_sweep($sformatf("row%0d", i), tbl[i].cycles, tbl[i].err,
                         tbl[i].fail, tbl[i].ffv);
            tick();
            check($sformatf("row%0d_done_pulse", i), 32'(done), 0);
            check($sformatf("row%0d_hold_err", i), 32'(err_count), tbl[i].err);
            tick();
        end

        // start in the done cycle: next sweep begins with no lost cycle, counters cleared
        begin_sweep(1, 12'hFFF);
        finish_sweep("b2b_first", tbl[1].cycles, tbl[1].err, 1, 0);
        mode  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_vec0", 32'(vec), 0);
        check("b2b_busy", 32'(busy), 1);
        check("b2b_done_low", 32'(done), 0);
        check("b2b_err_clr", 32'(err_count), 0);
        check("b2b_fail_clr", 32'(fail), 0);
        finish_sweep("b2b_second", 64, 0, 0, 0);
        tick();

        // start mid-sweep is ignored
        begin_sweep(0, 12'hFFF);
        repeat (20) tick();
        check("midstart_vec20", 32'(vec), 20);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("midstart_vec21", 32'(vec), 21);
        finish_sweep("midstart", 43, 0, 0, 0);
        tick();

        // abort mid-sweep returns to IDLE without done
        begin_sweep(0, 12'hFFF);
        repeat (20) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_err", 32'(err_count), 0);
        tick();
        check("abort_done_later", 32'(done), 0);
        check("abort_busy_later", 32'(busy), 0);

        // reset mid-sweep with accumulated errors
        begin_sweep(1, 12'hFFF);
        repeat (20) tick();
        check("prerst_err", 32'(err_count), 20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_vec", 32'(vec), 0);
        check("midrst_err", 32'(err_count), 0);
        check("midrst_fail", 32'(fail), 0);
        check("midrst_ffv", 32'(first_fail_vec), 0);
        tick();
        check("midrst_no_done", 32'(done), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
